// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, controller states and instruction classes
// for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [7:0] OP_LD0   = 8'h81;
  localparam logic [7:0] OP_LD1   = 8'h85;
  localparam logic [7:0] OP_ST0   = 8'h83;
  localparam logic [7:0] OP_ST1   = 8'h87;
  localparam logic [7:0] OP_PUSH  = 8'h89;
  localparam logic [7:0] OP_POP   = 8'h8B;
  localparam logic [3:0] CLASS_BR = 4'h3;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MEM,
    SP_UPD,
    HALT
  } ctrl_state_t;

  typedef enum logic [2:0] {
    ALU,
    BR,
    LD,
    ST,
    PUSH,
    POP,
    ILL
  } instr_class_t;

endpackage

// File: rtl/cpu_control_mc_if.sv
// Instruction-fetch handshake and data-memory request bus of the
// multi-cycle control unit. The controller uses the slave side; the
// fetch unit / memory model uses the master side.
interface cpu_control_mc_if #(
  parameter int INSTR_W = 32,
  parameter int SP_W    = 32
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               mem_ready;
  logic               datamem_write_en;
  logic               datamem_read_en;
  logic               stack_addr_sel;
  logic [SP_W-1:0]    stack_addr;

  modport slave (
    input  instr, instr_valid, mem_ready,
    output instr_ready, datamem_write_en, datamem_read_en,
           stack_addr_sel, stack_addr
  );

  modport master (
    output instr, instr_valid, mem_ready,
    input  instr_ready, datamem_write_en, datamem_read_en,
           stack_addr_sel, stack_addr
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier: maps the 8-bit opcode onto the
// instruction class that drives the controller sequencing.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [7:0]   op_i,
  output instr_class_t cls_o
);

  // Classify opcode; anything not explicitly recognised is illegal.
  always_comb begin
    cls_o = ILL;
    if (op_i[7:4] <= 4'h2) begin
      cls_o = ALU;
    end else if (op_i[7:4] == CLASS_BR) begin
      cls_o = BR;
    end else begin
      case (op_i)
        OP_LD0, OP_LD1: cls_o = LD;
        OP_ST0, OP_ST1: cls_o = ST;
        OP_PUSH:        cls_o = PUSH;
        OP_POP:         cls_o = POP;
        default:        cls_o = ILL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_mc.sv
// Multi-cycle CPU control unit: accepts one instruction per handshake,
// registers its decoded fields, sequences memory accesses against
// mem_ready and maintains the stack pointer for PUSH/POP.
module cpu_control_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int              INSTR_W = 32,
  parameter int              SP_W    = 32,
  parameter logic [SP_W-1:0] SP_INIT = 32'h0000_FFFC,
  parameter int              SP_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_control_mc_if.slave      bus,
  output logic [7:0]           alu_op,
  output logic                 alu_imm_src,
  output logic                 rf_write_en,
  output logic                 rf_write_mem_src,
  output logic                 pc_src,
  output logic                 pc_jmp_src,
  output logic [SP_W-1:0]      sp,
  output logic                 instr_done,
  output logic                 err
);

  localparam logic [SP_W-1:0] STEP = SP_W'(SP_STEP);

  ctrl_state_t     state_q, state_d;
  instr_class_t    cls_q, dec_cls;
  logic [7:0]      op_q;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic            accept;
  logic [7:0]      op_in;

  assign op_in = bus.instr[INSTR_W-1 -: 8];

  cpu_ctrl_decode u_decode (
    .op_i  (op_in),
    .cls_o (dec_cls)
  );

  // State, stack pointer, error flag and latched instruction fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= SP_INIT;
      err_q   <= 1'b0;
      op_q    <= 8'h00;
      cls_q   <= ALU;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      if (accept) begin
        op_q  <= op_in;
        cls_q <= dec_cls;
      end
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d              = state_q;
    sp_d                 = sp_q;
    err_d                = err_q;
    accept               = 1'b0;
    bus.instr_ready      = 1'b0;
    bus.datamem_read_en  = 1'b0;
    bus.datamem_write_en = 1'b0;
    bus.stack_addr_sel   = 1'b0;
    bus.stack_addr       = '0;
    rf_write_en          = 1'b0;
    rf_write_mem_src     = 1'b0;
    pc_src               = 1'b0;
    instr_done           = 1'b0;

    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept = 1'b1;
          if (dec_cls == ILL) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        case (cls_q)
          ALU: begin
            rf_write_en = 1'b1;
            instr_done  = 1'b1;
            state_d     = IDLE;
          end
          BR: begin
            pc_src     = 1'b1;
            instr_done = 1'b1;
            state_d    = IDLE;
          end
          default: state_d = MEM;
        endcase
      end

      MEM: begin
        bus.datamem_read_en  = (cls_q == LD) || (cls_q == POP);
        bus.datamem_write_en = (cls_q == ST) || (cls_q == PUSH);
        bus.stack_addr_sel   = (cls_q == PUSH) || (cls_q == POP);
        if (bus.stack_addr_sel) begin
          // PUSH pre-decrements; POP reads at the current top.
          bus.stack_addr = (cls_q == PUSH) ? (sp_q - STEP) : sp_q;
        end
        if (bus.mem_ready) begin
          if ((cls_q == LD) || (cls_q == POP)) begin
            rf_write_en      = 1'b1;
            rf_write_mem_src = 1'b1;
          end
          if ((cls_q == LD) || (cls_q == ST)) begin
            instr_done = 1'b1;
            state_d    = IDLE;
          end else begin
            // Commit sp on entry to SP_UPD so it is visible when done pulses.
            sp_d    = (cls_q == PUSH) ? (sp_q - STEP) : (sp_q + STEP);
            state_d = SP_UPD;
          end
        end
      end

      SP_UPD: begin
        instr_done = 1'b1;
        state_d    = IDLE;
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase
  end

  assign alu_op      = op_q;
  assign alu_imm_src = op_q[0];
  assign pc_jmp_src  = op_q[1];
  assign sp          = sp_q;
  assign err         = err_q;

endmodule
